// File: rtl/dig_core_pkg.sv
// Shared definitions for the dig_core host-link command path.
//   CMD_WRITE / CMD_READ : command byte encodings of a host frame
//   FRAME_LEN            : bytes per host frame (command, address, data)
//   uart_cmd_state_t     : state encoding of uart_cmd_slave
//   cmd_is_valid()       : true for command bytes the slave executes
package dig_core_pkg;

    localparam logic [7:0]  CMD_WRITE = 8'h01;
    localparam logic [7:0]  CMD_READ  = 8'h02;
    localparam int unsigned FRAME_LEN = 3;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_DATA,
        S_EXEC,
        S_RDWAIT,
        S_TX,
        S_TXWAIT
    } uart_cmd_state_t;

    function automatic logic cmd_is_valid(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout for host frames: a loadable down-counter.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   clear            : reload to TIMEOUT_CYCLES-1 (a byte arrived)
//   enable           : count down while a frame is partially received
//   expired          : one-cycle pulse when an enabled count reaches zero
// The count starts at TIMEOUT_CYCLES-1 on clear, so expiry falls on the
// TIMEOUT_CYCLES-th cycle after the clearing byte. clear has priority, so a
// byte arriving on the expiry cycle suppresses the pulse.
module uart_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (clear) begin
            cnt_d = LoadVal;
        end else if (enable) begin
            if (cnt_q == '0) begin
                expired = 1'b1;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_slave.sv
// Host command responder: parses 3-byte frames (command, address, data) from
// the UART receiver and turns them into register writes or register reads
// whose result is returned as one byte on the UART transmitter.
//   sys_clk, sys_rst     : clock, synchronous active-high reset
//   rx_data, rx_done     : received byte and its one-cycle strobe
//   tx_data, tx_wr       : reply byte and one-cycle transmit request
//   tx_done              : transmitter finished the reply byte
//   reg_addr, reg_wdata  : register address and write data
//   reg_wr, reg_rd       : one-cycle register write / read strobes
//   reg_rdata            : read data, valid the cycle after reg_rd
//   err_o                : one-cycle pulse on any protocol error
//   last_cmd_o           : last executed valid command byte
module uart_cmd_slave
    import dig_core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned ADDR_W         = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              err_o,
    output logic [7:0]        last_cmd_o
);

    uart_cmd_state_t   state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              cmd_bad_q, cmd_bad_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        last_cmd_q, last_cmd_d;

    logic timer_en;
    logic timeout;
    logic busy;

    // Only a partially received frame is subject to the inter-byte timeout.
    assign timer_en = (state_q == S_ADDR) || (state_q == S_DATA);

    // States in which an incoming byte cannot be accepted.
    assign busy = (state_q == S_EXEC) || (state_q == S_RDWAIT) ||
                  (state_q == S_TX)   || (state_q == S_TXWAIT);

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (rx_done),
        .enable  (timer_en),
        .expired (timeout)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cmd_bad_d  = cmd_bad_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        last_cmd_d = last_cmd_q;
        reg_wr     = 1'b0;
        reg_rd     = 1'b0;
        tx_wr      = 1'b0;
        err_o      = 1'b0;

        unique case (state_q)
            S_CMD: begin
                // Unknown commands still consume a whole frame; the error is
                // reported once the frame is complete.
                if (rx_done) begin
                    cmd_d     = rx_data;
                    cmd_bad_d = !cmd_is_valid(rx_data);
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_done) begin
                    addr_d  = ADDR_W'(rx_data);
                    state_d = S_DATA;
                end else if (timeout) begin
                    err_o   = 1'b1;
                    state_d = S_CMD;
                end
            end
            S_DATA: begin
                if (rx_done) begin
                    data_d  = rx_data;
                    state_d = S_EXEC;
                end else if (timeout) begin
                    err_o   = 1'b1;
                    state_d = S_CMD;
                end
            end
            S_EXEC: begin
                state_d = S_CMD;
                if (cmd_bad_q) begin
                    err_o = 1'b1;
                end else begin
                    last_cmd_d = cmd_q;
                    if (cmd_q == CMD_READ) begin
                        reg_rd  = 1'b1;
                        state_d = S_RDWAIT;
                    end else begin
                        reg_wr = 1'b1;
                    end
                end
            end
            S_RDWAIT: begin
                tx_data_d = reg_rdata;
                state_d   = S_TX;
            end
            S_TX: begin
                tx_wr   = 1'b1;
                state_d = S_TXWAIT;
            end
            S_TXWAIT: begin
                if (tx_done) begin
                    state_d = S_CMD;
                end
            end
            default: begin
                state_d = S_CMD;
            end
        endcase

        // A byte arriving while a frame is being executed or answered is lost.
        if (rx_done && busy) begin
            err_o = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_CMD;
            cmd_q      <= '0;
            cmd_bad_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            tx_data_q  <= '0;
            last_cmd_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cmd_bad_q  <= cmd_bad_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            last_cmd_q <= last_cmd_d;
        end
    end

    assign reg_addr   = addr_q;
    assign reg_wdata  = data_q;
    assign tx_data    = tx_data_q;
    assign last_cmd_o = last_cmd_q;

endmodule
